huffman_table_lut: RTL and testbench
====================================

// Module: huffman_table_lut
// PURPOSE
//   Fixed Huffman code table for the huffman_coder datapath.
//   - Maps a 7-bit ASCII character to a prefix-free code of 3..8 bits plus its length.
//   - Outputs are registered, one cycle after the character is presented.
//   - Sits between the character input and the coder FSM, which captures code/length in its ENCODE state.
// PARAMETERS
//   none (table contents fixed; constants in huffman_pkg)
// PORTS
//   clk           in   1   system clock, all state on rising edge
//   reset         in   1   asynchronous, active-low reset
//   ascii         in   7   input character (7-bit ASCII)
//   huffman_code  out  10  code, right-aligned; bits above bit_length-1 are 0
//   bit_length    out  4   number of valid code bits (3..8); 0 only during/after reset
//   escape        out  1   1 when ascii is outside the table and ESC is emitted
// BEHAVIOUR
//   - Clock and reset: one clock (clk); reset is asynchronous and active-low.
//   - While reset=0: huffman_code=0, bit_length=0, escape=0, asynchronously.
//   - Latency: outputs at rising edge N+1 reflect ascii sampled at edge N+1.
//     Outputs stay stable while ascii is stable. No handshake and no FSM.
//   - Case fold: 'A'..'Z' (0x41..0x5A) map as 'a'..'z'; fold = ascii|0x20.
//   - Canonical table (symbol: code / length):
//     ' ' 000/3   e 001/3
//     t 0100   a 0101   o 0110   i 0111   n 1000   s 1001  (length 4)
//     h 10100  r 10101  d 10110  l 10111  c 11000  u 11001  (length 5)
//     m 110100 w 110101 f 110110 g 110111 y 111000 p 111001 b 111010 v 111011 (length 6)
//     k 1111000/7   j 1111001/7
//     x 11110100/8  q 11110101/8  z 11110110/8
//     ESC 11110111/8: every other ascii value, including digits, punctuation,
//       control codes and 0x7F; escape=1.
//   - Codes are canonical and prefix-free. MSB of the code is transmitted first,
//     at bit position bit_length-1.
//   - Boundary values:
//     - 0x40 '@', 0x5B '[', 0x60 '`' and 0x7B '{' map to ESC.
//     - 0x00 maps to ESC, not to a zero-length code.
//   - Changing ascii every cycle yields a new valid lookup every cycle.
//   - A reset asserted mid-stream clears the outputs immediately.
//     The first valid output comes at the first rising edge after reset deasserts.
// STRUCTURE
//   - huffman_pkg:
//     - per-symbol code and length localparams;
//     - ESC_CODE=10'b0011110111, ESC_LEN=4'd8;
//     - width constants CODE_W=10, LEN_W=4, ASCII_W=7.
//   - Datapath:
//     - combinational fold: ascii_fold, a small function or sub-module;
//     - case-statement ROM;
//     - output register stage with async active-low clear.
//   - No further sub-modules.
// TESTING
//   1. reset=0 with ascii=0x65 -> outputs 0/0/0. Release reset, next edge
//      -> huffman_code=10'b0000000001, bit_length=3, escape=0.
//   2. ascii=0x20 -> code 0, length 3; ascii=0x74 't' -> 10'b0000000100, length 4.
//   3. ascii=0x5A 'Z' and 0x7A 'z' -> both give 10'b0011110110, length 8, escape=0.
//   4. ascii=0x31 '1', 0x40, 0x7B, 0x00 -> each gives 10'b0011110111, length 8, escape=1.
//   5. Sweep all 128 values back to back, one per cycle:
//      - each output matches the model one cycle later;
//      - no code is a prefix of another;
//      - upper bits of the code are 0.
//   6. Assert reset for 1 cycle mid-sweep -> outputs 0 at once; lookups resume after release.

Source files
------------

// File: rtl/huffman_pkg.sv
// Constants for the fixed canonical Huffman table: widths, per-symbol codes/lengths,
// the escape code, and the upper-case fold helper.
package huffman_pkg;

  localparam int CODE_W  = 10;
  localparam int LEN_W   = 4;
  localparam int ASCII_W = 7;

  localparam logic [CODE_W-1:0] CODE_SPACE = 10'b0000000000;
  localparam logic [CODE_W-1:0] CODE_E     = 10'b0000000001;
  localparam logic [CODE_W-1:0] CODE_T     = 10'b0000000100;
  localparam logic [CODE_W-1:0] CODE_A     = 10'b0000000101;
  localparam logic [CODE_W-1:0] CODE_O     = 10'b0000000110;
  localparam logic [CODE_W-1:0] CODE_I     = 10'b0000000111;
  localparam logic [CODE_W-1:0] CODE_N     = 10'b0000001000;
  localparam logic [CODE_W-1:0] CODE_S     = 10'b0000001001;
  localparam logic [CODE_W-1:0] CODE_H     = 10'b0000010100;
  localparam logic [CODE_W-1:0] CODE_R     = 10'b0000010101;
  localparam logic [CODE_W-1:0] CODE_D     = 10'b0000010110;
  localparam logic [CODE_W-1:0] CODE_L     = 10'b0000010111;
  localparam logic [CODE_W-1:0] CODE_C     = 10'b0000011000;
  localparam logic [CODE_W-1:0] CODE_U     = 10'b0000011001;
  localparam logic [CODE_W-1:0] CODE_M     = 10'b0000110100;
  localparam logic [CODE_W-1:0] CODE_W_SYM = 10'b0000110101;
  localparam logic [CODE_W-1:0] CODE_F     = 10'b0000110110;
  localparam logic [CODE_W-1:0] CODE_G     = 10'b0000110111;
  localparam logic [CODE_W-1:0] CODE_Y     = 10'b0000111000;
  localparam logic [CODE_W-1:0] CODE_P     = 10'b0000111001;
  localparam logic [CODE_W-1:0] CODE_B     = 10'b0000111010;
  localparam logic [CODE_W-1:0] CODE_V     = 10'b0000111011;
  localparam logic [CODE_W-1:0] CODE_K     = 10'b0001111000;
  localparam logic [CODE_W-1:0] CODE_J     = 10'b0001111001;
  localparam logic [CODE_W-1:0] CODE_X     = 10'b0011110100;
  localparam logic [CODE_W-1:0] CODE_Q     = 10'b0011110101;
  localparam logic [CODE_W-1:0] CODE_Z     = 10'b0011110110;
  localparam logic [CODE_W-1:0] ESC_CODE   = 10'b0011110111;

  localparam logic [LEN_W-1:0] LEN_3   = 4'd3;
  localparam logic [LEN_W-1:0] LEN_4   = 4'd4;
  localparam logic [LEN_W-1:0] LEN_5   = 4'd5;
  localparam logic [LEN_W-1:0] LEN_6   = 4'd6;
  localparam logic [LEN_W-1:0] LEN_7   = 4'd7;
  localparam logic [LEN_W-1:0] LEN_8   = 4'd8;
  localparam logic [LEN_W-1:0] ESC_LEN = 4'd8;

  // Only 'A'..'Z' are folded; setting bit 5 elsewhere would alias '@', '[' etc. onto letters.
  function automatic logic [ASCII_W-1:0] ascii_fold(input logic [ASCII_W-1:0] ch);
    if (ch >= 7'h41 && ch <= 7'h5A) return ch | 7'h20;
    else                            return ch;
  endfunction

endpackage

// File: rtl/huffman_table_lut.sv
// Registered lookup of the fixed Huffman table: folds case, decodes via a case ROM,
// and registers code/length/escape with an asynchronous active-low clear.
module huffman_table_lut
  import huffman_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [ASCII_W-1:0] ascii,
  output logic [CODE_W-1:0]  huffman_code,
  output logic [LEN_W-1:0]   bit_length,
  output logic               escape
);

  logic [ASCII_W-1:0] ascii_fold_w;
  logic [CODE_W-1:0]  code_d, code_q;
  logic [LEN_W-1:0]   len_d,  len_q;
  logic               esc_d,  esc_q;

  assign ascii_fold_w = ascii_fold(ascii);

  // Anything not listed falls through to the escape code, including 0x00.
  always_comb begin
    code_d = ESC_CODE;
    len_d  = ESC_LEN;
    esc_d  = 1'b1;
    unique case (ascii_fold_w)
      7'h20: begin code_d = CODE_SPACE; len_d = LEN_3; esc_d = 1'b0; end
      7'h65: begin code_d = CODE_E;     len_d = LEN_3; esc_d = 1'b0; end
      7'h74: begin code_d = CODE_T;     len_d = LEN_4; esc_d = 1'b0; end
      7'h61: begin code_d = CODE_A;     len_d = LEN_4; esc_d = 1'b0; end
      7'h6F: begin code_d = CODE_O;     len_d = LEN_4; esc_d = 1'b0; end
      7'h69: begin code_d = CODE_I;     len_d = LEN_4; esc_d = 1'b0; end
      7'h6E: begin code_d = CODE_N;     len_d = LEN_4; esc_d = 1'b0; end
      7'h73: begin code_d = CODE_S;     len_d = LEN_4; esc_d = 1'b0; end
      7'h68: begin code_d = CODE_H;     len_d = LEN_5; esc_d = 1'b0; end
      7'h72: begin code_d = CODE_R;     len_d = LEN_5; esc_d = 1'b0; end
      7'h64: begin code_d = CODE_D;     len_d = LEN_5; esc_d = 1'b0; end
      7'h6C: begin code_d = CODE_L;     len_d = LEN_5; esc_d = 1'b0; end
      7'h63: begin code_d = CODE_C;     len_d = LEN_5; esc_d = 1'b0; end
      7'h75: begin code_d = CODE_U;     len_d = LEN_5; esc_d = 1'b0; end
      7'h6D: begin code_d = CODE_M;     len_d = LEN_6; esc_d = 1'b0; end
      7'h77: begin code_d = CODE_W_SYM; len_d = LEN_6; esc_d = 1'b0; end
      7'h66: begin code_d = CODE_F;     len_d = LEN_6; esc_d = 1'b0; end
      7'h67: begin code_d = CODE_G;     len_d = LEN_6; esc_d = 1'b0; end
      7'h79: begin code_d = CODE_Y;     len_d = LEN_6; esc_d = 1'b0; end
      7'h70: begin code_d = CODE_P;     len_d = LEN_6; esc_d = 1'b0; end
      7'h62: begin code_d = CODE_B;     len_d = LEN_6; esc_d = 1'b0; end
      7'h76: begin code_d = CODE_V;     len_d = LEN_6; esc_d = 1'b0; end
      7'h6B: begin code_d = CODE_K;     len_d = LEN_7; esc_d = 1'b0; end
      7'h6A: begin code_d = CODE_J;     len_d = LEN_7; esc_d = 1'b0; end
      7'h78: begin code_d = CODE_X;     len_d = LEN_8; esc_d = 1'b0; end
      7'h71: begin code_d = CODE_Q;     len_d = LEN_8; esc_d = 1'b0; end
      7'h7A: begin code_d = CODE_Z;     len_d = LEN_8; esc_d = 1'b0; end
      default: ;
    endcase
  end

  // A zero length marks "no lookup yet" to the coder while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q <= '0;
      len_q  <= '0;
      esc_q  <= 1'b0;
    end else begin
      code_q <= code_d;
      len_q  <= len_d;
      esc_q  <= esc_d;
    end
  end

  assign huffman_code = code_q;
  assign bit_length   = len_q;
  assign escape       = esc_q;

endmodule

// File: tb/tb_huffman_table_lut.sv
// Self-checking bench for huffman_table_lut against a canonical-Huffman model
// built from symbol order and code lengths.
module tb_huffman_table_lut;

  logic       clk;
  logic       reset;
  logic [6:0] ascii;
  logic [9:0] huffman_code;
  logic [3:0] bit_length;
  logic       escape;

  int total = 0;
  int bad   = 0;

  string      syms;
  int         symLen  [27];
  logic [9:0] symCode [27];
  logic [9:0] escCode;
  logic [9:0] obsCode [128];
  logic [3:0] obsLen  [128];

  huffman_table_lut dut (
    .clk          (clk),
    .reset        (reset),
    .ascii        (ascii),
    .huffman_code (huffman_code),
    .bit_length   (bit_length),
    .escape       (escape)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Canonical assignment: increment within a length, shift left when the length grows.
  task automatic buildModel();
    int lens [27] = '{3,3, 4,4,4,4,4,4, 5,5,5,5,5,5, 6,6,6,6,6,6,6,6, 7,7, 8,8,8};
    int code = 0;
    int prev = 3;
    syms = " etaoinshrdlcumwfgypbvkjxqz";
    for (int i = 0; i < 27; i++) begin
      code = code << (lens[i] - prev);
      prev = lens[i];
      symLen[i]  = lens[i];
      symCode[i] = code[9:0];
      code++;
    end
    escCode = code[9:0];
  endtask

  task automatic model(input logic [6:0] a, output logic [9:0] c,
                       output logic [3:0] l, output logic e);
    int f = (a >= 7'h41 && a <= 7'h5A) ? int'(a) + 32 : int'(a);
    c = escCode;
    l = 4'd8;
    e = 1'b1;
    for (int i = 0; i < 27; i++) begin
      if (int'(syms[i]) == f) begin
        c = symCode[i];
        l = symLen[i][3:0];
        e = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [9:0] c, input logic [3:0] l, input logic e);
    checkOutput({tag, ".code"}, 32'(huffman_code), 32'(c));
    checkOutput({tag, ".len"},  32'(bit_length),   32'(l));
    checkOutput({tag, ".esc"},  32'(escape),       32'(e));
  endtask

  task automatic applyStimulus(input logic [6:0] a);
    ascii = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] mc;
    logic [3:0] ml;
    logic       me;
    int         order [128];
    int         j, tmp, li, lj;
    logic [6:0] escVals [4] = '{7'h31, 7'h40, 7'h7B, 7'h00};
    logic [6:0] bnd [2] = '{7'h5B, 7'h60};

    buildModel();

    // Reset held with a valid character present
    reset = 1'b0;
    ascii = 7'h65;
    #3;
    checkAll("reset_async", 10'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    checkAll("reset_held", 10'd0, 4'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkAll("first_e", 10'b0000000001, 4'd3, 1'b0);

    applyStimulus(7'h20);
    checkAll("space", 10'd0, 4'd3, 1'b0);
    applyStimulus(7'h74);
    checkAll("t", 10'b0000000100, 4'd4, 1'b0);
    applyStimulus(7'h5A);
    checkAll("Z", 10'b0011110110, 4'd8, 1'b0);
    applyStimulus(7'h7A);
    checkAll("z", 10'b0011110110, 4'd8, 1'b0);
    foreach (escVals[k]) begin
      applyStimulus(escVals[k]);
      checkAll($sformatf("esc_%02h", escVals[k]), 10'b0011110111, 4'd8, 1'b1);
    end
    foreach (bnd[k]) begin
      applyStimulus(bnd[k]);
      checkAll($sformatf("bound_%02h", bnd[k]), 10'b0011110111, 4'd8, 1'b1);
    end

    // Shuffled full sweep, one value per cycle, with a reset pulse partway through
    for (int i = 0; i < 128; i++) order[i] = i;
    for (int i = 127; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 128; i++) begin
      if (i == 64) begin
        #2 reset = 1'b0;
        #1;
        checkAll("midreset_now", 10'd0, 4'd0, 1'b0);
        @(posedge clk); #1;
        checkAll("midreset_hold", 10'd0, 4'd0, 1'b0);
        reset = 1'b1;
      end
      applyStimulus(7'(order[i]));
      model(7'(order[i]), mc, ml, me);
      checkAll($sformatf("sweep_%02h", order[i]), mc, ml, me);
      checkOutput($sformatf("upper_%02h", order[i]), 32'(huffman_code >> bit_length), 32'd0);
      obsCode[order[i]] = huffman_code;
      obsLen[order[i]]  = bit_length;
    end

    // Prefix-freedom over the observed codes of distinct lengths
    for (int a = 0; a < 128; a++) begin
      for (int b = 0; b < 128; b++) begin
        li = int'(obsLen[a]);
        lj = int'(obsLen[b]);
        if (li > 0 && li < lj) begin
          checkOutput($sformatf("prefix_%02h_%02h", a, b),
                      32'((obsCode[b] >> (lj - li)) == obsCode[a]), 32'd0);
        end
      end
    end

    // Random stream of back-to-back lookups
    for (int i = 0; i < 200; i++) begin
      logic [6:0] r;
      r = 7'($urandom_range(127, 0));
      applyStimulus(r);
      model(r, mc, ml, me);
      checkAll($sformatf("rand_%02h", r), mc, ml, me);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
